// File: rtl/tff_pkg.sv
// Mode encodings shared by the T flip-flop counter and its users.
// Pure declarations: no logic, no latency, no flow control.
// Import with tff_pkg::* wherever the mode field is decoded.
package tff_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_TOGGLE = 2'b00;
  localparam mode_t MODE_UP     = 2'b01;
  localparam mode_t MODE_DOWN   = 2'b10;
  localparam mode_t MODE_LOAD   = 2'b11;

endpackage

// File: rtl/tff_cell.sv
// One bit of the counter: a T flip-flop with a parallel-load override.
// Latency 1 cycle; state only changes on posedge clk.
// No backpressure; precedence is rst > ld > tog.
module tff_cell (
  input  logic clk,
  input  logic rst,
  input  logic tog,
  input  logic ld,
  input  logic d,
  output logic q
);

  logic r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= 1'b0;
    end else if (ld) begin
      r_q <= d;
    end else if (tog) begin
      r_q <= ~r_q;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/tff_mod_counter.sv
// Bank of T flip-flops: per-bit toggle register or modulo-N up/down counter with load, tc and sticky ovf.
// Latency 1 cycle from sampling edge to q/tc/ovf; qb is combinational ~q.
// No backpressure: en=0 holds q and zeroes tc; TFF_CNT_SATURATE_EN turns wraps into holds at the limit.
module tff_mod_counter
  import tff_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MODULUS = 2 ** WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] w_up_tog;
  logic [WIDTH-1:0] w_dn_tog;
  logic [WIDTH-1:0] w_tog;
  logic [WIDTH-1:0] w_ld;
  logic [WIDTH-1:0] w_d;
  logic             w_evt;
  logic             r_tc;
  logic             r_ovf;

  // T-chain: a bit flips counting up when every lower bit is 1, counting down when every lower bit is 0.
  always_comb begin
    w_mask   = '0;
    w_up_tog = '0;
    w_dn_tog = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_mask      = (WIDTH'(1) << i) - WIDTH'(1);
      w_up_tog[i] = &(w_q | ~w_mask);
      w_dn_tog[i] = ~|(w_q & w_mask);
    end
  end

  always_comb begin
    w_tog = '0;
    w_ld  = '0;
    w_d   = '0;
    w_evt = 1'b0;
    if (en) begin
      case (mode_t'(mode))
        MODE_TOGGLE: begin
          w_tog = t;
        end
        MODE_UP: begin
          if (w_q >= MAX_VAL) begin
            w_evt = 1'b1;
            w_ld  = '1;
`ifdef TFF_CNT_SATURATE_EN
            w_d   = MAX_VAL;
`else
            w_d   = '0;
`endif
          end else begin
            w_tog = w_up_tog;
          end
        end
        MODE_DOWN: begin
          if (w_q == '0) begin
            w_evt = 1'b1;
            w_ld  = '1;
`ifdef TFF_CNT_SATURATE_EN
            w_d   = '0;
`else
            w_d   = MAX_VAL;
`endif
          end else if (w_q > MAX_VAL) begin
            // Out-of-range value left by TOGGLE: pull back into range silently.
            w_ld = '1;
            w_d  = MAX_VAL;
          end else begin
            w_tog = w_dn_tog;
          end
        end
        default: begin
          w_ld = '1;
          w_d  = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end
      endcase
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    tff_cell u_cell (
      .clk (clk),
      .rst (rst),
      .tog (w_tog[g]),
      .ld  (w_ld[g]),
      .d   (w_d[g]),
      .q   (w_q[g])
    );
  end

  // A wrap event outranks a same-cycle clear so no overrun is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tc  <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      r_tc <= w_evt;
      if (w_evt) begin
        r_ovf <= 1'b1;
      end else if (clr_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign q   = w_q;
  assign qb  = ~w_q;
  assign tc  = r_tc;
  assign ovf = r_ovf;

endmodule

// File: tb/tb_tff_mod_counter.sv
// Directed and randomized checks of tff_mod_counter (WIDTH=8, MODULUS=10) against an arithmetic model.
module tb_tff_mod_counter;

  localparam int W   = 8;
  localparam int MOD = 10;

  logic         clk;
  logic         rst;
  logic         en;
  logic [1:0]   mode;
  logic [W-1:0] t;
  logic [W-1:0] load_val;
  logic         clr_ovf;
  logic [W-1:0] q;
  logic [W-1:0] qb;
  logic         tc;
  logic         ovf;

  int n_total = 0;
  int n_bad   = 0;

  int unsigned mq;
  bit          mtc;
  bit          movf;

`ifdef TFF_CNT_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  tff_mod_counter #(.WIDTH(W), .MODULUS(MOD)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .t        (t),
    .load_val (load_val),
    .clr_ovf  (clr_ovf),
    .q        (q),
    .qb       (qb),
    .tc       (tc),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Apply one cycle of inputs, clock it, and advance the reference model by the arithmetic rules.
  task automatic step(input bit r, input bit e, input bit [1:0] m,
                      input bit [7:0] tv, input bit [7:0] lv, input bit c);
    int unsigned nq;
    bit          ev;
    nq = mq;
    ev = 1'b0;
    rst = r; en = e; mode = m; t = tv; load_val = lv; clr_ovf = c;
    if (!r && e) begin
      case (m)
        2'd0: nq = (mq ^ tv) % 256;
        2'd1: begin
          if (mq >= MOD - 1) begin ev = 1'b1; nq = SAT ? MOD - 1 : 0; end
          else nq = mq + 1;
        end
        2'd2: begin
          if (mq == 0) begin ev = 1'b1; nq = SAT ? 0 : MOD - 1; end
          else if (mq >= MOD) nq = MOD - 1;
          else nq = mq - 1;
        end
        default: nq = (lv > MOD - 1) ? MOD - 1 : lv;
      endcase
    end
    @(posedge clk);
    #1;
    if (r) begin
      mq = 0; mtc = 1'b0; movf = 1'b0;
    end else begin
      mq   = nq;
      mtc  = ev;
      movf = ev ? 1'b1 : (c ? 1'b0 : movf);
    end
  endtask

  task automatic test_reset();
    step(1, 0, 2'd0, 8'h00, 8'h00, 0);
    n_total++; if (q !== 8'h00)  begin n_bad++; $display("FAIL rst0_q got=%h want=00", q); end
    n_total++; if (qb !== 8'hFF) begin n_bad++; $display("FAIL rst0_qb got=%h want=FF", qb); end
    n_total++; if (tc !== 1'b0)  begin n_bad++; $display("FAIL rst0_tc got=%b want=0", tc); end
    n_total++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL rst0_ovf got=%b want=0", ovf); end
    step(0, 1, 2'd1, 8'h00, 8'h00, 0);
    step(0, 1, 2'd3, 8'h00, 8'h09, 0);
    step(0, 1, 2'd1, 8'h00, 8'h00, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 2'd0, 8'($urandom), 8'h00, 0);
    step(1, 1, 2'd1, 8'h00, 8'h00, 0);
    n_total++; if (q !== 8'h00)  begin n_bad++; $display("FAIL rst1_q got=%h want=00", q); end
    n_total++; if (qb !== 8'hFF) begin n_bad++; $display("FAIL rst1_qb got=%h want=FF", qb); end
    n_total++; if (tc !== 1'b0)  begin n_bad++; $display("FAIL rst1_tc got=%b want=0", tc); end
    n_total++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL rst1_ovf got=%b want=0", ovf); end
  endtask

  task automatic test_up_wrap();
    logic [7:0] wq;
    wq = SAT ? 8'd9 : 8'd0;
    step(0, 1, 2'd3, 8'h00, 8'd8, 0);
    n_total++; if (q !== 8'd8) begin n_bad++; $display("FAIL up_load q=%0d want=8", q); end
    step(0, 1, 2'd1, 8'h00, 8'h00, 0);
    n_total++; if (q !== 8'd9) begin n_bad++; $display("FAIL up_9 q=%0d want=9", q); end
    n_total++; if (tc !== 1'b0) begin n_bad++; $display("FAIL up_9_tc got=%b want=0", tc); end
    step(0, 1, 2'd1, 8'h00, 8'h00, 0);
    n_total++; if (q !== wq) begin n_bad++; $display("FAIL up_wrap_q got=%0d want=%0d", q, wq); end
    n_total++; if (tc !== 1'b1) begin n_bad++; $display("FAIL up_wrap_tc got=%b want=1", tc); end
    n_total++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL up_wrap_ovf got=%b want=1", ovf); end
    step(0, 0, 2'd1, 8'h00, 8'h00, 0);
    n_total++; if (q !== wq) begin n_bad++; $display("FAIL up_hold_q got=%0d want=%0d", q, wq); end
    n_total++; if (tc !== 1'b0) begin n_bad++; $display("FAIL up_hold_tc got=%b want=0", tc); end
    n_total++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL up_hold_ovf got=%b want=1", ovf); end
  endtask

  task automatic test_down_wrap();
    step(0, 1, 2'd3, 8'h00, 8'd0, 0);
    step(0, 1, 2'd2, 8'h00, 8'h00, 0);
    n_total++; if (q !== (SAT ? 8'd0 : 8'd9)) begin n_bad++; $display("FAIL dn_wrap_q got=%0d want=%0d", q, SAT ? 0 : 9); end
    n_total++; if (tc !== 1'b1) begin n_bad++; $display("FAIL dn_wrap_tc got=%b want=1", tc); end
    step(0, 1, 2'd2, 8'h00, 8'h00, 0);
    n_total++; if (q !== (SAT ? 8'd0 : 8'd8)) begin n_bad++; $display("FAIL dn_next_q got=%0d want=%0d", q, SAT ? 0 : 8); end
    n_total++; if (tc !== SAT) begin n_bad++; $display("FAIL dn_next_tc got=%b want=%b", tc, SAT); end
    n_total++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL dn_next_ovf got=%b want=1", ovf); end
  endtask

  task automatic test_toggle_en();
    step(0, 0, 2'd0, 8'hFF, 8'h00, 1);
    n_total++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL clr_en0_ovf got=%b want=0", ovf); end
    step(0, 1, 2'd3, 8'h00, 8'd0, 0);
    step(0, 1, 2'd0, 8'h0F, 8'h00, 0);
    n_total++; if (q !== 8'h0F) begin n_bad++; $display("FAIL tog_0f got=%h want=0F", q); end
    step(0, 1, 2'd0, 8'hFF, 8'h00, 0);
    n_total++; if (q !== 8'hF0) begin n_bad++; $display("FAIL tog_f0 got=%h want=F0", q); end
    n_total++; if (tc !== 1'b0) begin n_bad++; $display("FAIL tog_tc got=%b want=0", tc); end
    step(0, 0, 2'd0, 8'hFF, 8'h00, 0);
    n_total++; if (q !== 8'hF0) begin n_bad++; $display("FAIL tog_en0 got=%h want=F0", q); end
    n_total++; if (qb !== 8'h0F) begin n_bad++; $display("FAIL tog_en0_qb got=%h want=0F", qb); end
    step(0, 1, 2'd2, 8'h00, 8'h00, 0);
    n_total++; if (q !== 8'd9) begin n_bad++; $display("FAIL dn_clamp_q got=%0d want=9", q); end
    n_total++; if (tc !== 1'b0) begin n_bad++; $display("FAIL dn_clamp_tc got=%b want=0", tc); end
    n_total++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL dn_clamp_ovf got=%b want=0", ovf); end
    step(0, 1, 2'd0, 8'hF9, 8'h00, 0);
    step(0, 1, 2'd1, 8'h00, 8'h00, 0);
    n_total++; if (q !== (SAT ? 8'd9 : 8'd0)) begin n_bad++; $display("FAIL up_oor_q got=%0d want=%0d", q, SAT ? 9 : 0); end
    n_total++; if (tc !== 1'b1) begin n_bad++; $display("FAIL up_oor_tc got=%b want=1", tc); end
  endtask

  task automatic test_simultaneous();
    step(0, 1, 2'd3, 8'h00, 8'd9, 1);
    n_total++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL sim_pre_ovf got=%b want=0", ovf); end
    step(0, 1, 2'd1, 8'h00, 8'h00, 1);
    n_total++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL sim_set_ovf got=%b want=1", ovf); end
    n_total++; if (tc !== 1'b1) begin n_bad++; $display("FAIL sim_set_tc got=%b want=1", tc); end
    step(0, 1, 2'd3, 8'h00, 8'hFF, 1);
    n_total++; if (q !== 8'd9) begin n_bad++; $display("FAIL sim_ld_q got=%0d want=9", q); end
    n_total++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL sim_clr_ovf got=%b want=0", ovf); end
    n_total++; if (tc !== 1'b0) begin n_bad++; $display("FAIL sim_ld_tc got=%b want=0", tc); end
  endtask

`ifdef TFF_CNT_SATURATE_EN
  task automatic test_saturate();
    step(0, 1, 2'd3, 8'h00, 8'd9, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 2'd1, 8'h00, 8'h00, 0);
      n_total++; if (q !== 8'd9) begin n_bad++; $display("FAIL sat_q[%0d] got=%0d want=9", i, q); end
      n_total++; if (tc !== 1'b1) begin n_bad++; $display("FAIL sat_tc[%0d] got=%b want=1", i, tc); end
      n_total++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL sat_ovf[%0d] got=%b want=1", i, ovf); end
    end
  endtask
`endif

  task automatic test_random();
    bit        r, e, c;
    bit [1:0]  m;
    bit [7:0]  tv, lv;
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 40) == 0);
      e  = ($urandom_range(0, 3) != 0);
      m  = 2'($urandom_range(0, 3));
      tv = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'($urandom_range(0, 15));
      lv = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'($urandom_range(0, 12));
      c  = ($urandom_range(0, 7) == 0);
      step(r, e, m, tv, lv, c);
      n_total++; if (q !== 8'(mq)) begin n_bad++; $display("FAIL rnd_q[%0d] got=%0d want=%0d", i, q, mq); end
      n_total++; if (qb !== ~8'(mq)) begin n_bad++; $display("FAIL rnd_qb[%0d] got=%h want=%h", i, qb, ~8'(mq)); end
      n_total++; if (tc !== mtc) begin n_bad++; $display("FAIL rnd_tc[%0d] got=%b want=%b", i, tc, mtc); end
      n_total++; if (ovf !== movf) begin n_bad++; $display("FAIL rnd_ovf[%0d] got=%b want=%b", i, ovf, movf); end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'd0; t = '0; load_val = '0; clr_ovf = 1'b0;
    mq = 0; mtc = 1'b0; movf = 1'b0;
    #1;
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_toggle_en();
    test_simultaneous();
`ifdef TFF_CNT_SATURATE_EN
    test_saturate();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
